// File: rtl/noc_pe_pkg.sv
// Shared defaults for the NoC/PE datapath blocks.
package noc_pe_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 256;
endpackage

// File: rtl/bram_fifo.sv
// Convenience wrapper: FIFO controller plus an inferred simple dual-port RAM
// with a registered read address.
module bram_fifo
  import noc_pe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] din, dout;
  logic [ADDR_WIDTH-1:0] addrin, addrout, addrout_reg;
  logic                  we, re;

  bram_fifo_ctrl #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ctrl (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .bram_din(din), .bram_addrin(addrin), .bram_we(we),
    .bram_addrout(addrout), .bram_re(re), .bram_dout(dout),
    .count(count), .empty(empty), .full(full)
  );

  // No reset on the RAM side so it maps onto block RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[addrin] <= din;
    if (re) addrout_reg <= addrout;
  end

  assign dout = mem[addrout_reg];

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external simple dual-port block RAM
// with a registered read address; hides the one-cycle read latency.
module bram_fifo_ctrl
  import noc_pe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [ADDR_WIDTH-1:0] bram_addrin,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addrout,
  output logic                  bram_re,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   pend, pend_n;
  logic                  m_valid_n;
  logic                  push, fetch, pop;

  // The displayed head still lives in RAM (bram_dout is continuous), so it
  // counts toward occupancy until popped; this keeps writes off its slot.
  assign count   = pend + {{ADDR_WIDTH{1'b0}}, m_valid};
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign s_ready = !full;

  assign push  = s_valid & s_ready;
  assign fetch = (pend != '0) & (!m_valid | m_ready);
  assign pop   = m_valid & m_ready;

  assign bram_din     = s_data;
  assign bram_addrin  = wr_ptr;
  assign bram_we      = push;
  assign bram_addrout = rd_ptr;
  assign bram_re      = fetch;
  assign m_data       = bram_dout;

  always_comb begin
    pend_n    = pend + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, fetch};
    m_valid_n = m_valid;
    if (fetch)    m_valid_n = 1'b1;
    else if (pop) m_valid_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pend    <= '0;
      m_valid <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
      pend    <= pend_n;
      m_valid <= m_valid_n;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural block RAM.
module tb_bram_fifo_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_valid, bram_we, bram_re, empty, full;
  logic [DW-1:0] m_data, bram_din, bram_dout;
  logic [AW-1:0] bram_addrin, bram_addrout;
  logic [AW:0]   count;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .bram_din(bram_din), .bram_addrin(bram_addrin), .bram_we(bram_we),
    .bram_addrout(bram_addrout), .bram_re(bram_re), .bram_dout(bram_dout),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // behavioural RAM: write port plus registered read address
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ar = '0;
  always @(posedge clk) begin
    if (bram_we) mem[bram_addrin] <= bram_din;
    if (bram_re) ar <= bram_addrout;
  end
  assign bram_dout = mem[ar];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int mc = 0, mp = 0, mv = 0, wp = 0, rp = 0, cyc = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_pop;
  int pop_cyc = -1, pops = 0;

  task automatic model_reset();
    mc = 0; mp = 0; mv = 0; wp = 0; rp = 0; q.delete();
  endtask

  // called at a falling edge: drive, check, advance model, wait next falling edge
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic ep, ef, eo;
    s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    ep = sv && (mc != DEPTH);
    ef = (mp != 0) && (mv == 0 || mr);
    eo = (mv != 0) && mr;
    chk("s_ready", s_ready, mc != DEPTH);
    chk("m_valid", m_valid, mv != 0);
    chk("count", count, mc);
    chk("empty", empty, mc == 0);
    chk("full", full, mc == DEPTH);
    chk("bram_we", bram_we, ep);
    chk("bram_re", bram_re, ef);
    chk("addrin", bram_addrin, wp);
    chk("addrout", bram_addrout, rp);
    chk("din", bram_din, sd);
    if (eo) begin
      last_pop = q.pop_front();
      chk("m_data", m_data, last_pop);
      pop_cyc = cyc; pops++;
    end
    if (ep) begin q.push_back(sd); wp = (wp + 1) % DEPTH; end
    if (ef) rp = (rp + 1) % DEPTH;
    mp = mp + int'(ep) - int'(ef);
    mv = ef ? 1 : (eo ? 0 : mv);
    mc = mp + mv;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] held, first;
    int t0, guard;

    // reset with random inputs
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'($urandom); m_ready = 1'($urandom); s_data = $urandom;
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_re", bram_re, 0);
      chk("rst_we", bram_we, s_valid);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("idle_no_pops", pops, 0);

    // single entry latency
    t0 = cyc;
    step(1, 32'hDEADBEEF, 1);
    chk("single_re", bram_re, 1);
    step(0, 0, 1);
    chk("single_mv", m_valid, 1);
    chk("single_data", m_data, 32'hDEADBEEF);
    step(0, 0, 1);
    chk("single_lat", pop_cyc - t0, 2);
    chk("single_pop", last_pop, 32'hDEADBEEF);
    step(0, 0, 1);
    chk("single_empty", empty, 1);

    // fill, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0);
    chk("fill_count", count, DEPTH);
    chk("fill_full", full, 1);
    chk("fill_ready", s_ready, 0);
    step(1, 32'h0BAD_0BAD, 0);
    chk("ovf_count", count, DEPTH);
    pops = 0;
    step(0, 0, 1);
    first = last_pop;
    chk("drain_first", first, 0);
    guard = 0;
    while (mc != 0 && guard < 400) begin step(0, 0, 1); guard++; end
    chk("drain_bound", guard < 400, 1);
    chk("drain_pops", pops, DEPTH);
    chk("drain_last", last_pop, DEPTH - 1);
    chk("drain_empty", empty, 1);

    // streaming with pointer wrap
    pops = 0;
    for (int i = 0; i < 600; i++) step(1, 32'h1000 + DW'(i), 1);
    chk("stream_pops", pops, 598);
    chk("stream_last", last_pop, 32'h1000 + 597);
    chk("stream_count", count, 2);
    guard = 0;
    while (mc != 0 && guard < 10) begin step(0, 0, 1); guard++; end
    chk("stream_drain", last_pop, 32'h1000 + 599);

    // backpressure: head held stable, no fetch
    step(1, 32'hA0, 0);
    step(1, 32'hA1, 0);
    held = m_data;
    chk("bp_head", held, 32'hA0);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'hB0 + DW'(i), 0);
      chk("bp_hold", m_data, held);
      chk("bp_re", bram_re, 0);
    end
    pops = 0;
    guard = 0;
    while (mc != 0 && guard < 20) begin step(0, 0, 1); guard++; end
    chk("bp_pops", pops, 7);
    chk("bp_last", last_pop, 32'hB4);

    // reset mid-stream with 10 queued
    for (int i = 0; i < 10; i++) step(1, 32'hC0 + DW'(i), 0);
    chk("mid_count", count, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mv", m_valid, 0);
    chk("mid_rst_count", count, 0);
    model_reset();
    @(negedge clk);
    s_valid = 0; m_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pops = 0;
    step(1, 32'h1, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("post_rst_pops", pops, 1);
    chk("post_rst_first", last_pop, 32'h1);
    chk("post_rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- FIFO controller that drives an external simple dual-port block RAM through its write port (din/addrin/we) and its registered-address read port (addrout/re/dout).
- Turns the raw memory into a valid/ready stream buffer, e.g. a spike-packet queue between the router and the PE.
- Hides the one-cycle read latency and sustains one push and one pop per cycle.
- The block RAM is instantiated by the parent; this block owns all pointer, occupancy and handshake logic.

Parameters:
- DATA_WIDTH, 32, width of each entry; must equal the block RAM width.
- DEPTH, 256, number of entries; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), localparam; width of the RAM addresses and pointers.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream push request.
- s_ready  out  1  FIFO can accept an entry; equals !full.
- s_data  in  DATA_WIDTH  entry to push.
- m_valid  out  1  head entry is present on m_data.
- m_ready  in  1  downstream accepts the head entry.
- m_data  out  DATA_WIDTH  head entry; driven straight from bram_dout.
- bram_din  out  DATA_WIDTH  write data to RAM; equals s_data.
- bram_addrin  out  ADDR_WIDTH  write address; equals wr_ptr.
- bram_we  out  1  RAM write enable; equals s_valid & s_ready.
- bram_addrout  out  ADDR_WIDTH  read address; equals rd_ptr.
- bram_re  out  1  RAM read-address latch enable (fetch).
- bram_dout  in  DATA_WIDTH  RAM read data; reflects the address latched on the previous re.
- count  out  ADDR_WIDTH+1  total occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr = 0, rd_ptr = 0, count = 0, pend = 0, m_valid = 0.
  - Outputs while in reset: s_ready = 1, empty = 1, full = 0, bram_re = 0; bram_we = s_valid.
  - RAM contents are not cleared. Reset mid-operation discards every entry; any push handshake in that cycle is lost.
- State:
  - pend = number of written entries not yet fetched.
  - count = pend + m_valid.
  - A fetched entry still occupies its RAM slot until popped, because bram_dout reads the memory continuously.
- Push:
  - push = s_valid & s_ready.
  - On push: RAM is written at wr_ptr, then wr_ptr+1 mod DEPTH (natural wrap).
  - Full: s_ready = 0, including when a pop happens in the same cycle (no full-bypass). The entry becomes poppable next cycle.
- Fetch (combinational):
  - bram_re = (pend != 0) & (!m_valid | m_ready).
  - On fetch: rd_ptr+1 mod DEPTH, and m_valid is 1 in the next cycle.
  - A pushed entry is never fetched in its write cycle (pend counts it only from the next cycle), so there is no read/write collision.
- Pop:
  - pop = m_valid & m_ready.
  - If pop and no fetch: m_valid goes to 0 next cycle.
  - If pop and fetch: m_valid stays 1 and m_data shows the next entry next cycle, giving back-to-back throughput of 1/cycle.
- Stall: while m_valid & !m_ready, bram_re = 0, so addrout_reg and m_data are held stable (AXI-style stability).
- Latency: push accepted in cycle t → m_valid = 1 at t+2 (fetch at t+1) when the FIFO was empty.
- Simultaneous push and pop: count unchanged; pend updates as pend + push - fetch.
- Arithmetic:
  - count is ADDR_WIDTH+1 bits.
  - Pointers are ADDR_WIDTH bits with wrap by overflow.
  - No DEPTH-1 special cases.
- Protocol errors: s_valid while full is simply not accepted. No error flag.

Decomposition:
- Shared package `noc_pe_pkg`: default DATA_WIDTH (32) and DEPTH (256).
- No typedefs are required.
- No sub-module; optional thin wrapper `bram_fifo` instantiating this controller plus the block RAM for the bench and PE use.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → m_valid = 0, count = 0, empty = 1, s_ready = 1, bram_re = 0. Release → idle, no spurious pops.
- Single entry: push 0xDEADBEEF at cycle t with m_ready = 1 → bram_we at t, bram_re at t+1, m_valid = 1 with m_data = 0xDEADBEEF at t+2, then empty.
- Fill: push 256 entries with m_ready = 0 → count = 256, full = 1, s_ready = 0. A 257th s_valid is ignored. Draining returns 0..255 in order.
- Streaming: s_valid = m_ready = 1 continuously for 600 cycles with an incrementing pattern → one pop per cycle after 2-cycle fill, in-order data, pointers wrap past 255 without loss.
- Backpressure: with m_valid = 1, hold m_ready = 0 for 5 cycles while pushing → m_data stable, bram_re = 0; resume → sequence intact.
- Reset mid-stream: assert rst_n low with 10 entries queued → immediate m_valid = 0, count = 0. After release, a new push 0x1 is popped as the first entry.
